// File: rtl/mtm_alu_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// mtm_alu_tx_scheduler_if : request/holding handshakes and serializer image bus
// Revision: 1.0
// ============================================================================
interface mtm_alu_tx_scheduler_if;
  logic        res_valid;
  logic [31:0] res_c;
  logic [7:0]  res_ctl;
  logic        res_ready;
  logic        err_valid;
  logic [7:0]  err_ctl;
  logic        err_ready;
  logic [54:0] aluin;
  logic        dataready;
  logic        ovf;

  modport master (
    output res_valid, res_c, res_ctl, err_valid, err_ctl,
    input  res_ready, err_ready, aluin, dataready, ovf
  );

  modport slave (
    input  res_valid, res_c, res_ctl, err_valid, err_ctl,
    output res_ready, err_ready, aluin, dataready, ovf
  );
endinterface
`default_nettype wire

// File: rtl/mtm_alu_tx_scheduler.sv
`default_nettype none
// ============================================================================
// mtm_alu_tx_scheduler : buffers one result and one error frame, feeds the
// serializer one paced 55-bit image. MTM_ALU_TX_RR_EN: round-robin grant.
// Revision: 1.0
// ============================================================================
module mtm_alu_tx_scheduler #(
  parameter int GUARD = 4,
  parameter int CNT_W = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  mtm_alu_tx_scheduler_if.slave        tx_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RES_LEN = CNT_W'(55 + GUARD);
  localparam logic [CNT_W-1:0] ERR_LEN = CNT_W'(11 + GUARD);

  state_t           state_q;
  logic             res_full_q;
  logic             err_full_q;
  logic [31:0]      res_c_q;
  logic [7:0]       res_ctl_q;
  logic [7:0]       err_ctl_q;
  logic [54:0]      aluin_q;
  logic             dataready_q;
  logic             ovf_q;
  logic             frame_err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             grant_err;

  function automatic logic [10:0] word(input logic t, input logic [7:0] b);
    return {1'b0, t, b, 1'b1};
  endfunction

  assign cnt_d = cnt_q - CNT_W'(1);

`ifdef MTM_ALU_TX_RR_EN
  logic last_err_q;
  // On a tie the requester not served last wins.
  assign grant_err = err_full_q && (!res_full_q || !last_err_q);
`else
  assign grant_err = err_full_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      res_full_q  <= 1'b0;
      err_full_q  <= 1'b0;
      res_c_q     <= '0;
      res_ctl_q   <= '0;
      err_ctl_q   <= '0;
      aluin_q     <= '0;
      dataready_q <= 1'b0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
`ifdef MTM_ALU_TX_RR_EN
      last_err_q  <= 1'b0;
`endif
    end else begin
      dataready_q <= 1'b0;

      // Capture only into an empty register; grant only releases a full one.
      if (tx_if.res_valid) begin
        if (!res_full_q) begin
          res_full_q <= 1'b1;
          res_c_q    <= tx_if.res_c;
          res_ctl_q  <= tx_if.res_ctl;
        end else begin
          ovf_q <= 1'b1;
        end
      end
      if (tx_if.err_valid) begin
        if (!err_full_q) begin
          err_full_q <= 1'b1;
          err_ctl_q  <= tx_if.err_ctl;
        end else begin
          ovf_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (res_full_q || err_full_q) begin
            if (grant_err) begin
              aluin_q    <= {44'd0, word(1'b1, err_ctl_q)};
              err_full_q <= 1'b0;
            end else begin
              aluin_q    <= {word(1'b0, res_c_q[31:24]), word(1'b0, res_c_q[23:16]),
                             word(1'b0, res_c_q[15:8]),  word(1'b0, res_c_q[7:0]),
                             word(1'b1, res_ctl_q)};
              res_full_q <= 1'b0;
            end
            frame_err_q <= grant_err;
`ifdef MTM_ALU_TX_RR_EN
            last_err_q  <= grant_err;
`endif
            dataready_q <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_q   <= frame_err_q ? ERR_LEN : RES_LEN;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Leaving on the decremented value gives a grant-to-grant period of len+GUARD+1.
          cnt_q <= cnt_d;
          if (cnt_d == CNT_W'(1)) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_if.aluin     = aluin_q;
  assign tx_if.dataready = dataready_q;
  assign tx_if.ovf       = ovf_q;
  assign tx_if.res_ready = !res_full_q;
  assign tx_if.err_ready = !err_full_q;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_tx_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mtm_alu_tx_scheduler : directed and random frames against a transaction
// level model of grants, holding registers and frame pacing.
// ============================================================================
module tb_mtm_alu_tx_scheduler;
  localparam int GUARD = 4;
  localparam int CNT_W = 7;
`ifdef MTM_ALU_TX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mtm_alu_tx_scheduler_if bus ();

  mtm_alu_tx_scheduler #(.GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: pending requests, earliest next grant edge, expected outputs.
  int          cyc = 0;
  int          m_next = 0;
  bit          m_res_full, m_err_full, m_ovf, m_dr, m_last_err;
  logic [31:0] m_res_c;
  logic [7:0]  m_res_ctl, m_err_ctl;
  logic [54:0] m_aluin;

  function automatic logic [10:0] w(input bit t, input logic [7:0] b);
    return 11'd1 + 11'(b) * 11'd2 + (t ? 11'd512 : 11'd0);
  endfunction

  function automatic logic [54:0] img(input bit is_err, input logic [31:0] c, input logic [7:0] ctl);
    logic [54:0] r;
    if (is_err) return 55'(w(1'b1, ctl));
    r = '0;
    for (int i = 3; i >= 0; i--) r = (r << 11) | 55'(w(1'b0, c[8*i +: 8]));
    return (r << 11) | 55'(w(1'b1, ctl));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the current inputs, then compare all outputs.
  task automatic step();
    bit o_res, o_err, g, ge;
    o_res = m_res_full;
    o_err = m_err_full;
    if (!rst) begin
      m_res_full = 0; m_err_full = 0; m_ovf = 0; m_dr = 0; m_last_err = 0;
      m_aluin = '0; m_next = 0;
    end else begin
      g  = (cyc >= m_next) && (o_res || o_err);
      ge = o_err && (!o_res || !RR || !m_last_err);
      m_dr = g;
      if (g) begin
        if (ge) begin
          m_aluin = img(1'b1, 32'd0, m_err_ctl);
          m_err_full = 0;
          m_next = cyc + 11 + GUARD + 1;
        end else begin
          m_aluin = img(1'b0, m_res_c, m_res_ctl);
          m_res_full = 0;
          m_next = cyc + 55 + GUARD + 1;
        end
        m_last_err = ge;
      end
      if (bus.res_valid) begin
        if (!o_res) begin m_res_full = 1; m_res_c = bus.res_c; m_res_ctl = bus.res_ctl; end
        else m_ovf = 1;
      end
      if (bus.err_valid) begin
        if (!o_err) begin m_err_full = 1; m_err_ctl = bus.err_ctl; end
        else m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("dataready", 64'(bus.dataready), 64'(m_dr));
    check("aluin",     64'(bus.aluin),     64'(m_aluin));
    check("res_ready", 64'(bus.res_ready), 64'(!m_res_full));
    check("err_ready", 64'(bus.err_ready), 64'(!m_err_full));
    check("ovf",       64'(bus.ovf),       64'(m_ovf));
  endtask

  task automatic wait_dr(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.dataready && n < budget);
    check(tag, 64'(bus.dataready), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.res_valid = 1'b0;
    bus.err_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  localparam logic [54:0] T2_IMG = {11'h025, 11'h069, 11'h0AD, 11'h0F1, 11'h20B};

  initial begin
    int          n;
    bit          stable;
    int          drs;
    logic [31:0] a_c;
    logic [7:0]  a_ctl;

    bus.res_valid = 1'b0; bus.res_c = '0; bus.res_ctl = '0;
    bus.err_valid = 1'b0; bus.err_ctl = '0;

    // Reset values
    do_reset();
    check("rst_aluin",     64'(bus.aluin),     64'd0);
    check("rst_dataready", 64'(bus.dataready), 64'd0);
    check("rst_ovf",       64'(bus.ovf),       64'd0);
    check("rst_res_ready", 64'(bus.res_ready), 64'd1);
    check("rst_err_ready", 64'(bus.err_ready), 64'd1);

    // Result frame: image layout, strobe latency, image held through the frame
    bus.res_valid = 1'b1; bus.res_c = 32'h12345678; bus.res_ctl = 8'h05;
    step();
    bus.res_valid = 1'b0;
    check("t2_ready_drop", 64'(bus.res_ready), 64'd0);
    step();
    check("t2_dataready", 64'(bus.dataready), 64'd1);
    check("t2_image", 64'(bus.aluin), 64'(T2_IMG));
    stable = 1; drs = 0;
    for (int i = 0; i < 59; i++) begin
      step();
      if (bus.aluin !== T2_IMG) stable = 0;
      if (bus.dataready) drs++;
    end
    check("t2_stable", 64'(stable), 64'd1);
    check("t2_no_restrobe", 64'(drs), 64'd0);

    // Error frame and minimum error-to-error spacing
    bus.err_valid = 1'b1; bus.err_ctl = 8'hC9;
    step();
    bus.err_valid = 1'b0;
    wait_dr("t3_dr", 10, n);
    check("t3_image", 64'(bus.aluin), 64'h393);
    bus.err_valid = 1'b1; bus.err_ctl = 8'h81;
    step();
    bus.err_valid = 1'b0;
    wait_dr("t3_dr2", 40, n);
    check("t3_gap", 64'(n + 1), 64'd16);
    check("t3_image2", 64'(bus.aluin), 64'(img(1'b1, 32'd0, 8'h81)));

    // Collisions: error first, then a tie with the last grant being an error
    do_reset();
    bus.res_valid = 1'b1; bus.res_c = 32'hDEADBEEF; bus.res_ctl = 8'h2A;
    bus.err_valid = 1'b1; bus.err_ctl = 8'hC1;
    step();
    bus.res_valid = 1'b0; bus.err_valid = 1'b0;
    step();
    check("t4_first_dr", 64'(bus.dataready), 64'd1);
    check("t4_first_err", 64'(bus.aluin[8]), 64'd1);
    bus.err_valid = 1'b1; bus.err_ctl = 8'hB3;
    step();
    bus.err_valid = 1'b0;
    wait_dr("t4_second_dr", 40, n);
    check("t4_second_gap", 64'(n + 1), 64'd16);
    check("t4_second_kind", 64'(bus.aluin[8]), RR ? 64'd0 : 64'd1);
    wait_dr("t4_third_dr", 80, n);
    check("t4_third_gap", 64'(n), RR ? 64'd60 : 64'd16);
    check("t4_third_kind", 64'(bus.aluin[8]), RR ? 64'd1 : 64'd0);

    // Overflow while the result register is held full behind an error frame
    do_reset();
    bus.err_valid = 1'b1; bus.err_ctl = 8'hC9;
    step();
    bus.err_valid = 1'b0;
    step();
    a_c = $urandom; a_ctl = 8'($urandom_range(0, 127));
    bus.res_valid = 1'b1; bus.res_c = a_c; bus.res_ctl = a_ctl;
    step();
    bus.res_c = ~a_c;
    step();
    bus.res_valid = 1'b0;
    step();
    bus.res_valid = 1'b1; bus.res_c = a_c ^ 32'h0F0F0F0F;
    step();
    bus.res_valid = 1'b0;
    check("t5_ovf", 64'(bus.ovf), 64'd1);
    wait_dr("t5_dr", 40, n);
    check("t5_first_kept", 64'(bus.aluin), 64'(img(1'b0, a_c, a_ctl)));
    for (int i = 0; i < 5; i++) step();
    check("t5_ovf_sticky", 64'(bus.ovf), 64'd1);

    // Reset in the middle of a result frame, then a normal error frame
    do_reset();
    bus.res_valid = 1'b1; bus.res_c = 32'hCAFEF00D; bus.res_ctl = 8'h11;
    step();
    bus.res_valid = 1'b0;
    wait_dr("t6_dr", 10, n);
    for (int i = 0; i < 10; i++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("t6_aluin", 64'(bus.aluin), 64'd0);
    check("t6_dataready", 64'(bus.dataready), 64'd0);
    check("t6_res_ready", 64'(bus.res_ready), 64'd1);
    check("t6_err_ready", 64'(bus.err_ready), 64'd1);
    bus.err_valid = 1'b1; bus.err_ctl = 8'hC9;
    step();
    bus.err_valid = 1'b0;
    wait_dr("t6_err_dr", 10, n);
    check("t6_err_image", 64'(bus.aluin), 64'h393);

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      rst           = ($urandom_range(0, 299) != 0);
      bus.res_valid = ($urandom_range(0, 9) == 0);
      bus.res_c     = $urandom;
      bus.res_ctl   = {1'b0, 7'($urandom)};
      bus.err_valid = ($urandom_range(0, 14) == 0);
      bus.err_ctl   = {1'b1, 7'($urandom)};
      step();
    end
    rst = 1'b1;
    bus.res_valid = 1'b0;
    bus.err_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
